// File: rtl/cpu_dbg_master_pkg.sv
// Shared definitions for the CPU debug master: command encodings, FSM states,
// single-step pulse width and op classification helpers.
package cpu_dbg_master_pkg;

  typedef enum logic [2:0] {
    OP_RD_DM = 3'd0,
    OP_RD_IM = 3'd1,
    OP_RD_RF = 3'd2,
    OP_WR_DM = 3'd3,
    OP_WR_IM = 3'd4,
    OP_RD_PC = 3'd5,
    OP_STEP  = 3'd6
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RD_WAIT,
    S_RESP
  } state_e;

  localparam int unsigned STEP_W = 4;

  function automatic logic is_write(op_e op);
    return (op == OP_WR_DM) || (op == OP_WR_IM);
  endfunction

  function automatic logic is_read(op_e op);
    return (op == OP_RD_DM) || (op == OP_RD_IM) || (op == OP_RD_RF) || (op == OP_RD_PC);
  endfunction

endpackage

// File: rtl/cpu_dbg_master_if.sv
// Command/response handshake between the serial debug parser/transmitter
// (master side) and cpu_dbg_master (slave side).
interface cpu_dbg_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [7:0]  cmd_len;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_last;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_len, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_last
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_len, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_last
  );
endinterface

// File: rtl/cpu_dbg_master_addr_ctr.sv
// Loadable 32-bit incrementing address counter with an 8-bit remaining-word
// count; last is high when the current word is the final one of the burst.
module dbg_addr_ctr (
  input  logic        clk,
  input  logic        rstn,
  input  logic        load,
  input  logic [31:0] load_addr,
  input  logic [7:0]  load_cnt,
  input  logic        inc,
  output logic [31:0] cur_addr,
  output logic        last
);
  logic [7:0] remain;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur_addr <= '0;
      remain   <= '0;
    end else if (load) begin
      cur_addr <= load_addr;
      remain   <= load_cnt;
    end else if (inc) begin
      cur_addr <= cur_addr + 32'd1;
      remain   <= remain - 8'd1;
    end
  end

  assign last = (remain == '0);
endmodule

// File: rtl/cpu_dbg_master.sv
// CPU debug-port master: turns parser commands into strobed writes and burst
// reads of the CPU debug port. CPU_DBG_MASTER_STEP_EN adds clk_step and op STEP.
module cpu_dbg_master
  import cpu_dbg_master_pkg::*;
(
  input  logic                   clk,
  input  logic                   rstn,
  cpu_dbg_master_if.slave        bus,
  output logic                   debug,
  output logic [31:0]            addr,
  output logic [31:0]            din,
  output logic                   we_dm,
  output logic                   we_im,
  output logic                   clk_ld,
  input  logic [31:0]            dout_dm,
  input  logic [31:0]            dout_im,
  input  logic [31:0]            dout_rf,
  input  logic [31:0]            pc_chk,
  output logic                   busy
`ifdef CPU_DBG_MASTER_STEP_EN
  ,
  output logic                   clk_step
`endif
);
  state_e      state;
  op_e         op_q;
  op_e         cmd_op;
  logic        accept;
  logic        ctr_load;
  logic        ctr_inc;
  logic        ctr_last;
  logic [31:0] ctr_ld_addr;
  logic [7:0]  ctr_ld_cnt;
  logic [31:0] rd_word;

  assign cmd_op        = op_e'(bus.cmd_op);
  assign accept        = (state == S_IDLE) && bus.cmd_valid;
  assign bus.cmd_ready = (state == S_IDLE);
  assign busy          = (state != S_IDLE);

  // Writes and RD_PC load a zero count; RD_PC reloads the current address so addr holds.
  assign ctr_load    = accept && (is_read(cmd_op) || is_write(cmd_op));
  assign ctr_ld_addr = (cmd_op == OP_RD_PC) ? addr : bus.cmd_addr;
  assign ctr_ld_cnt  = (is_read(cmd_op) && cmd_op != OP_RD_PC) ? bus.cmd_len : '0;
  assign ctr_inc     = (state == S_RESP) && bus.rsp_ready && !ctr_last;

  dbg_addr_ctr u_ctr (
    .clk       (clk),
    .rstn      (rstn),
    .load      (ctr_load),
    .load_addr (ctr_ld_addr),
    .load_cnt  (ctr_ld_cnt),
    .inc       (ctr_inc),
    .cur_addr  (addr),
    .last      (ctr_last)
  );

  always_comb begin
    rd_word = pc_chk;
    case (op_q)
      OP_RD_DM: rd_word = dout_dm;
      OP_RD_IM: rd_word = dout_im;
      OP_RD_RF: rd_word = dout_rf;
      default:  ;
    endcase
  end

`ifdef CPU_DBG_MASTER_STEP_EN
  localparam int unsigned STEP_CNT_W = $clog2(STEP_W);
  logic [STEP_CNT_W-1:0] step_cnt;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= S_IDLE;
      op_q          <= OP_RD_DM;
      din           <= '0;
      we_dm         <= 1'b0;
      we_im         <= 1'b0;
      clk_ld        <= 1'b0;
      debug         <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_last  <= 1'b0;
      bus.rsp_data  <= '0;
`ifdef CPU_DBG_MASTER_STEP_EN
      clk_step      <= 1'b0;
      step_cnt      <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          op_q  <= cmd_op;
          debug <= 1'b1;
          if (is_write(cmd_op)) begin
            din   <= bus.cmd_wdata;
            we_dm <= (cmd_op == OP_WR_DM);
            we_im <= (cmd_op == OP_WR_IM);
            state <= S_SETUP;
          end else if (is_read(cmd_op)) begin
            state <= S_SETUP;
          end
`ifdef CPU_DBG_MASTER_STEP_EN
          else if (cmd_op == OP_STEP) begin
            clk_step <= 1'b1;
            step_cnt <= STEP_CNT_W'(STEP_W - 1);
            state    <= S_STROBE;
          end
`endif
          else begin
            state <= S_HOLD;
          end
        end
        S_SETUP: begin
          if (is_write(op_q)) begin
            clk_ld <= 1'b1;
            state  <= S_STROBE;
          end else begin
            state  <= S_RD_WAIT;
          end
        end
        S_STROBE: begin
`ifdef CPU_DBG_MASTER_STEP_EN
          // STEP reuses STROBE as its pulse-timing state; clk_ld stays low.
          if (op_q == OP_STEP) begin
            if (step_cnt == '0) begin
              clk_step <= 1'b0;
              debug    <= 1'b0;
              state    <= S_IDLE;
            end else begin
              step_cnt <= step_cnt - 1'b1;
            end
          end else
`endif
          begin
            clk_ld <= 1'b0;
            state  <= S_HOLD;
          end
        end
        S_HOLD: begin
          we_dm <= 1'b0;
          we_im <= 1'b0;
          debug <= 1'b0;
          state <= S_IDLE;
        end
        S_RD_WAIT: begin
          bus.rsp_data  <= rd_word;
          bus.rsp_valid <= 1'b1;
          bus.rsp_last  <= ctr_last;
          state         <= S_RESP;
        end
        S_RESP: if (bus.rsp_ready) begin
          bus.rsp_valid <= 1'b0;
          bus.rsp_last  <= 1'b0;
          if (ctr_last) begin
            debug <= 1'b0;
            state <= S_IDLE;
          end else begin
            state <= S_SETUP;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_dbg_master.sv
// Randomized self-checking bench for cpu_dbg_master against an address/data
// reference model; honours CPU_DBG_MASTER_STEP_EN for the STEP op.
module tb_cpu_dbg_master;
  import cpu_dbg_master_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        debug, we_dm, we_im, clk_ld, busy;
  logic [31:0] addr, din, dout_dm, dout_im, dout_rf, pc_chk;
`ifdef CPU_DBG_MASTER_STEP_EN
  logic        clk_step;
`endif
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [31:0] model_addr = '0;
  logic        mon_en = 1'b0;

  cpu_dbg_master_if bus ();

  cpu_dbg_master dut (
    .clk     (clk),
    .rstn    (rstn),
    .bus     (bus),
    .debug   (debug),
    .addr    (addr),
    .din     (din),
    .we_dm   (we_dm),
    .we_im   (we_im),
    .clk_ld  (clk_ld),
    .dout_dm (dout_dm),
    .dout_im (dout_im),
    .dout_rf (dout_rf),
    .pc_chk  (pc_chk),
    .busy    (busy)
`ifdef CPU_DBG_MASTER_STEP_EN
    ,
    .clk_step(clk_step)
`endif
  );

  always #5 clk = ~clk;

  // CPU memories modelled as fixed functions of the address
  assign dout_dm = addr ^ 32'h5A5A_0000;
  assign dout_im = addr ^ 32'hA5A5_0000;
  assign dout_rf = ~addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_data(input logic [2:0] op, input logic [31:0] a);
    case (op)
      3'd0:    return a ^ 32'h5A5A_0000;
      3'd1:    return a ^ 32'hA5A5_0000;
      3'd2:    return ~a;
      default: return pc_chk;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rstn && mon_en) begin
      check("we_exclusive", {31'b0, we_dm & we_im}, 32'd0);
      check("clk_ld_without_we", {31'b0, clk_ld & ~(we_dm | we_im)}, 32'd0);
      check("debug_vs_busy", {31'b0, debug}, {31'b0, busy});
      check("ready_vs_busy", {31'b0, bus.cmd_ready}, {31'b0, ~busy});
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input logic [7:0] len);
    @(negedge clk);
    check("cmd_ready_idle", {31'b0, bus.cmd_ready}, 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = a;
    bus.cmd_wdata = wd;
    bus.cmd_len   = len;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'($urandom);
    bus.cmd_addr  = $urandom;
    bus.cmd_wdata = $urandom;
    bus.cmd_len   = 8'($urandom);
  endtask

  task automatic do_write(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
    int we_hit = 0;
    int we_other = 0;
    int ld = 0;
    logic done = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [31:0] ld_din = '0;
    issue(op, a, wd, 8'($urandom));
    for (int cyc = 0; cyc < 20; cyc++) begin
      if ((op == 3'd3) ? we_dm : we_im) we_hit++;
      if ((op == 3'd3) ? we_im : we_dm) we_other++;
      if (clk_ld) begin
        ld++;
        ld_addr = addr;
        ld_din  = din;
      end
      if (!busy) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("wr_done", {31'b0, done}, 32'd1);
    check("wr_we_cycles", we_hit, 32'd3);
    check("wr_other_we", we_other, 32'd0);
    check("wr_strobe_cycles", ld, 32'd1);
    check("wr_strobe_addr", ld_addr, a);
    check("wr_strobe_din", ld_din, wd);
    model_addr = a;
  endtask

  // mode 0: always ready, 1: random ready, 2: stall first word for 10 cycles
  task automatic do_read(input logic [2:0] op, input logic [31:0] a, input logic [7:0] len,
                         input int mode);
    int n = (op == 3'd5) ? 1 : int'(len) + 1;
    logic [31:0] base = (op == 3'd5) ? model_addr : a;
    int got = 0;
    int stall = 0;
    int strobes = 0;
    logic done = 1'b0;
    logic pend = 1'b0;
    logic rdy;
    logic [31:0] pd = '0;
    logic [31:0] pa = '0;
    logic [31:0] ea;
    pc_chk = $urandom;
    issue(op, a, 32'($urandom), len);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!busy) begin
        done = 1'b1;
        break;
      end
      if (clk_ld | we_dm | we_im) strobes++;
      if (bus.rsp_valid) begin
        if (pend) begin
          check("rsp_data_stable", bus.rsp_data, pd);
          check("addr_stable", addr, pa);
        end
        if (mode == 0) rdy = 1'b1;
        else if (mode == 2) rdy = !(got == 0 && stall < 10);
        else rdy = 1'($urandom_range(0, 1));
        if (!rdy) stall++;
        bus.rsp_ready = rdy;
        if (rdy) begin
          ea = base + 32'(got);
          check("rsp_addr", addr, ea);
          check("rsp_data", bus.rsp_data, ref_data(op, ea));
          check("rsp_last", {31'b0, bus.rsp_last}, {31'b0, got == n - 1});
          got++;
          pend = 1'b0;
        end else begin
          pend = 1'b1;
          pd   = bus.rsp_data;
          pa   = addr;
        end
      end else begin
        check("rsp_last_without_valid", {31'b0, bus.rsp_last}, 32'd0);
        bus.rsp_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    bus.rsp_ready = 1'b0;
    check("rd_done", {31'b0, done}, 32'd1);
    check("rd_words", got, n);
    check("rd_no_strobe", strobes, 32'd0);
    check("rd_valid_idle", {31'b0, bus.rsp_valid}, 32'd0);
    if (mode == 2) check("rd_stall_cycles", stall, 32'd10);
    if (op != 3'd5) model_addr = a + 32'(n - 1);
    check("addr_after_read", addr, model_addr);
  endtask

  task automatic do_illegal(input logic [2:0] op);
    int rdy_at = -1;
    int bad = 0;
    issue(op, 32'($urandom), 32'($urandom), 8'($urandom));
    for (int cyc = 1; cyc <= 8; cyc++) begin
      if (clk_ld | we_dm | we_im | bus.rsp_valid) bad++;
      if (bus.cmd_ready && rdy_at < 0) rdy_at = cyc;
      @(negedge clk);
    end
    check("illegal_ready_cycles", rdy_at, 32'd2);
    check("illegal_activity", bad, 32'd0);
    check("illegal_addr_kept", addr, model_addr);
  endtask

`ifdef CPU_DBG_MASTER_STEP_EN
  task automatic do_step();
    int hi = 0;
    int bad = 0;
    issue(3'd6, 32'($urandom), 32'($urandom), 8'($urandom));
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (clk_step) hi++;
      if (clk_ld | we_dm | we_im | bus.rsp_valid) bad++;
      @(negedge clk);
    end
    check("step_pulse_cycles", hi, 32'd4);
    check("step_activity", bad, 32'd0);
    check("step_idle", {31'b0, busy}, 32'd0);
  endtask
`endif

  task automatic do_reset_in_strobe();
    int seen = 0;
    int after = 0;
    issue(3'd4, 32'h0000_0123, 32'hCAFE_F00D, 8'd0);
    for (int cyc = 0; cyc < 10 && !clk_ld; cyc++) @(negedge clk);
    check("rst_reached_strobe", {31'b0, clk_ld}, 32'd1);
    rstn = 1'b0;
    #1;
    check("rst_clk_ld", {31'b0, clk_ld}, 32'd0);
    check("rst_we_im", {31'b0, we_im}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_debug", {31'b0, debug}, 32'd0);
    check("rst_addr", addr, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    model_addr = '0;
    repeat (10) begin
      @(negedge clk);
      if (clk_ld | we_dm | we_im) after++;
      if (busy) seen++;
    end
    check("rst_no_strobe_after", after, 32'd0);
    check("rst_stays_idle", seen, 32'd0);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_len   = '0;
    bus.rsp_ready = 1'b0;
    pc_chk        = 32'h1234_5678;
    repeat (3) @(negedge clk);
    check("reset_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("reset_rsp_last", {31'b0, bus.rsp_last}, 32'd0);
    check("reset_rsp_data", bus.rsp_data, 32'd0);
    check("reset_addr", addr, 32'd0);
    check("reset_din", din, 32'd0);
    check("reset_we", {30'b0, we_dm, we_im}, 32'd0);
    check("reset_clk_ld", {31'b0, clk_ld}, 32'd0);
    check("reset_debug_busy", {30'b0, debug, busy}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("reset_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
    mon_en = 1'b1;

    do_write(3'd3, 32'h0000_0010, 32'hDEAD_BEEF);
    do_read(3'd1, 32'h0000_0000, 8'd3, 0);
    do_read(3'd0, 32'h0000_4000, 8'd1, 2);
    do_read(3'd0, 32'hFFFF_FFFF, 8'd1, 0);
    do_read(3'd5, 32'h5555_AAAA, 8'd7, 1);
    do_write(3'd4, 32'h0000_0200, 32'h0BAD_F00D);
    do_read(3'd2, 32'h8000_0000, 8'd255, 0);
    do_illegal(3'd7);
`ifdef CPU_DBG_MASTER_STEP_EN
    do_step();
`else
    do_illegal(3'd6);
`endif
    do_reset_in_strobe();

    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom;
      case (op)
        3'd3, 3'd4: do_write(op, a, $urandom);
        3'd0, 3'd1, 3'd2, 3'd5: do_read(op, a, 8'($urandom_range(0, 9)), 1);
`ifdef CPU_DBG_MASTER_STEP_EN
        3'd6: do_step();
`endif
        default: do_illegal(op);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
